datapath: RTL
=============

# datapath

Processor datapath that executes the control word produced by the control unit `CU`: 5-bit program counter, 8-bit instruction register, 8-bit accumulator, add/subtract unit and a 32×8 unified program/data memory. It returns the opcode (`IR`) and accumulator status (`Aeq0`, `Apos`) to `CU`, closing the control/datapath loop. It sits beside `CU` under the processor top level.

## Interface

Parameters:
- `DW`, 8, data/accumulator width
- `AW`, 5, memory address and PC width (memory depth 2^AW)

Ports:
- `Clock`  in  1  system clock; all state updates on the rising edge
- `Reset`  in  1  synchronous, active-high reset
- `IRload`  in  1  load IR from memory
- `Aload`  in  1  load A from the Asel mux
- `Sub`  in  1  ALU op: 0 = A+M, 1 = A−M
- `JMPmux`  in  1  PC source: 0 = PC+1, 1 = IR[4:0]
- `PCload`  in  1  load PC from the JMPmux source
- `Meminst`  in  1  memory address: 0 = PC, 1 = IR[4:0]
- `MemWr`  in  1  write A to memory at the muxed address
- `Asel`  in  2  A source: 00 ALU, 01 `Input`, 10 memory data, 11 8'h00
- `Halt`  in  2  nonzero = processor halted
- `Input`  in  DW  external input switches
- `PrgWr`  in  1  program-load write strobe (honoured only while `Reset`=1)
- `PrgAddr`  in  AW  program-load address
- `PrgData`  in  DW  program-load data
- `IR`  out  3  opcode, IR register bits [7:5]
- `Aeq0`  out  1  A == 0
- `Apos`  out  1  A > 0 as signed (A[7]=0 and A≠0)
- `Output`  out  DW  output port, registered copy of A
- `Halted`  out  1  registered `|Halt`
- `PCout`  out  AW  current PC (debug)

## Operation

- Memory address mux: `madr = Meminst ? IRreg[4:0] : PC`. Read is asynchronous: `mdata = M[madr]`.
- IRload=1: IRreg <= mdata. With Meminst=0 this fetches M[PC].
- PCload=1: PC <= JMPmux ? IRreg[4:0] : PC+1, modulo 32 (31+1 = 0).
- Aload=1: A <= mux(Asel). ALU = Sub ? A−mdata : A+mdata, modulo 256. No carry or overflow flag.
- MemWr=1: M[madr] <= A, using the pre-edge A.
- Output <= A every cycle while Halted=0. It freezes while Halted=1.
- Halted <= |Halt.
- All control inputs are independent. IRload, PCload, Aload and MemWr may assert in the same cycle, and every one of them uses pre-edge register values.
- Reset=1 clears PC, IRreg, A, Output and Halted to 0. Memory contents are not cleared.
- PrgWr=1 with Reset=1: M[PrgAddr] <= PrgData. PrgWr with Reset=0 is ignored. MemWr is ignored during Reset.

## Timing

- Reset values: `IR`=3'b000, `Aeq0`=1, `Apos`=0, `Output`=0, `Halted`=0, `PCout`=0.
- `IR`, `PCout` and `Halted` are registered with 1-cycle latency. `Output` lags A by one cycle.
- `Aeq0` and `Apos` are combinational from the A register. They are valid in the same cycle A updates, so `CU` can branch on the next edge.
- Memory read data is valid in the same cycle as `madr`. A write becomes visible to reads the cycle after the edge.
- Reset asserted mid-instruction takes effect at the next edge and overrides every load and write.

## Structure

- Shared package `cpu_pkg` holds:
  - opcode constants LOAD=000, STORE=001, ADD=010, SUB=011, IN=100, JZ=101, JPOS=110, HALT=111
  - Asel encodings ASEL_ALU, ASEL_IN, ASEL_MEM, ASEL_ZERO
  - DW and AW defaults

  `CU` uses the same package.
- One sub-module, `ram32x8`: asynchronous read, synchronous write, with a single write port muxed between MemWr and PrgWr by `datapath`.

## Test plan

- Reset with PrgWr loading M[0]=8'h1E, M[30]=8'h05, then Reset=0. IRload=1, PCload=1, JMPmux=0 → IR=000, PCout=1.
- Next cycle: Meminst=1, Aload=1, Asel=10 → A=5, Aeq0=0, Apos=1. Next cycle: Output=5.
- A=5, M[30]=5, Sub=1, Asel=00, Aload → A=0, Aeq0=1. Again → A=8'hFB, Apos=0, Aeq0=0.
- A=8'h7F, Meminst=1, MemWr=1 with IRreg[4:0]=3 → M[3]=8'h7F, visible to a read next cycle. Same-cycle Aload with Asel=11 → A=0 and M[3] still gets 8'h7F.
- PC=31, PCload=1, JMPmux=0 → PC=0. JMPmux=1 with IRreg[4:0]=12 → PC=12.
- Halt=2'b01 → Halted=1 next cycle, and Output holds while A changes via Asel=01, Input=8'h33. Reset mid-sequence → all outputs at reset values, memory unchanged, PrgWr with Reset=0 has no effect.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the control unit and the datapath: opcodes,
// accumulator source encodings and default widths.
package cpu_pkg;

  localparam int DW_DEF = 8;
  localparam int AW_DEF = 5;

  typedef enum logic [2:0] {
    LOAD  = 3'b000,
    STORE = 3'b001,
    ADD   = 3'b010,
    SUB   = 3'b011,
    IN    = 3'b100,
    JZ    = 3'b101,
    JPOS  = 3'b110,
    HALT  = 3'b111
  } opcode_t;

  typedef enum logic [1:0] {
    ASEL_ALU  = 2'b00,
    ASEL_IN   = 2'b01,
    ASEL_MEM  = 2'b10,
    ASEL_ZERO = 2'b11
  } asel_t;

endpackage

// File: rtl/ram32x8.sv
// Unified program/data memory: asynchronous read, single synchronous write port.
module ram32x8 #(
  parameter int DW = 8,
  parameter int AW = 5
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/datapath.sv
// Processor datapath: PC, IR, accumulator, add/sub ALU and unified memory,
// executing the control word from CU and returning opcode and A status.
module datapath
  import cpu_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          IRload,
  input  logic          Aload,
  input  logic          Sub,
  input  logic          JMPmux,
  input  logic          PCload,
  input  logic          Meminst,
  input  logic          MemWr,
  input  logic [1:0]    Asel,
  input  logic [1:0]    Halt,
  input  logic [DW-1:0] Input,
  input  logic          PrgWr,
  input  logic [AW-1:0] PrgAddr,
  input  logic [DW-1:0] PrgData,
  output logic [2:0]    IR,
  output logic          Aeq0,
  output logic          Apos,
  output logic [DW-1:0] Output,
  output logic          Halted,
  output logic [AW-1:0] PCout
);

  logic [AW-1:0] r_pc;
  logic [DW-1:0] r_ir;
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_out;
  logic          r_halted;

  logic [AW-1:0] w_madr;
  logic [DW-1:0] w_mdata;
  logic [DW-1:0] w_alu;
  logic [DW-1:0] w_a_next;
  logic [AW-1:0] w_pc_next;
  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [DW-1:0] w_wdata;

  function automatic logic [DW-1:0] alu_addsub(input logic [DW-1:0] a,
                                               input logic [DW-1:0] b,
                                               input logic          sub);
    return sub ? (a - b) : (a + b);
  endfunction

  assign w_madr    = Meminst ? r_ir[AW-1:0] : r_pc;
  assign w_alu     = alu_addsub(r_a, w_mdata, Sub);
  assign w_pc_next = JMPmux ? r_ir[AW-1:0] : r_pc + 1'b1;

  always_comb begin
    w_a_next = '0;
    case (asel_t'(Asel))
      ASEL_ALU:  w_a_next = w_alu;
      ASEL_IN:   w_a_next = Input;
      ASEL_MEM:  w_a_next = w_mdata;
      ASEL_ZERO: w_a_next = '0;
      default:   w_a_next = '0;
    endcase
  end

  // The single write port belongs to the program loader while in reset,
  // and to MemWr (storing the pre-edge A) otherwise.
  assign w_we    = Reset ? PrgWr : MemWr;
  assign w_waddr = Reset ? PrgAddr : w_madr;
  assign w_wdata = Reset ? PrgData : r_a;

  ram32x8 #(
    .DW(DW),
    .AW(AW)
  ) u_ram (
    .i_clk  (Clock),
    .i_we   (w_we),
    .i_waddr(w_waddr),
    .i_wdata(w_wdata),
    .i_raddr(w_madr),
    .o_rdata(w_mdata)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_pc     <= '0;
      r_ir     <= '0;
      r_a      <= '0;
      r_out    <= '0;
      r_halted <= 1'b0;
    end else begin
      if (IRload) r_ir <= w_mdata;
      if (PCload) r_pc <= w_pc_next;
      if (Aload)  r_a  <= w_a_next;
      if (!r_halted) r_out <= r_a;
      r_halted <= |Halt;
    end
  end

  assign IR     = r_ir[DW-1:DW-3];
  assign Aeq0   = (r_a == '0);
  assign Apos   = !r_a[DW-1] && (r_a != '0);
  assign Output = r_out;
  assign Halted = r_halted;
  assign PCout  = r_pc;

endmodule
